mem_bus_arbiter: RTL and testbench

Owns the single downstream memory bus and shares it between the CPU core and an internal OAM DMA engine. Holds the two system registers that sequence the memory map: the boot-ROM disable latch at 0xFF50, which drives the boot ROM's `enabled` input, and the DMA trigger at 0xFF46. Sits between the CPU and the memory/IO decode. The boot ROM, cartridge, WRAM, OAM and IO all sit behind `bus_*`.

---
 rtl/gb_mem_pkg.sv | 30 +++
 rtl/oam_dma_engine.sv | 96 +++++++++
 rtl/mem_bus_arbiter.sv | 112 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants, DMA FSM state type and bus request bundle.
// Used by mem_bus_arbiter and oam_dma_engine.
package gb_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // System registers that are handled inside the arbiter
  localparam logic [ADDR_W-1:0] ADDR_BOOT_OFF = 16'hFF50;
  localparam logic [ADDR_W-1:0] ADDR_DMA      = 16'hFF46;

  // Default OAM DMA geometry
  localparam logic [ADDR_W-1:0] OAM_BASE_DEFAULT = 16'hFE00;
  localparam int unsigned       DMA_LEN_DEFAULT  = 160;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_READ  = 2'd1,
    DMA_WRITE = 2'd2
  } dma_state_e;

  // One downstream bus access
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } bus_req_t;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies DMA_LEN bytes from page {src,00} to OAM_BASE,
// one READ cycle followed by one WRITE cycle per byte.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start          - CPU write to the DMA register this cycle (start/restart)
//   start_src      - new source high byte
//   bus_rdata      - downstream read data, captured at the end of READ
//   req            - bus request bundle (combinational from state)
//   dma_active     - registered, high while state != IDLE
//   src            - current source high byte (register readback)
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int unsigned       DMA_LEN  = DMA_LEN_DEFAULT,
  parameter logic [ADDR_W-1:0] OAM_BASE = OAM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] start_src,
  input  logic [DATA_W-1:0] bus_rdata,
  output bus_req_t          req,
  output logic              dma_active,
  output logic [DATA_W-1:0] src
);

  localparam int unsigned IDX_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  dma_state_e        state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [DATA_W-1:0] latch, latch_next;
  logic [DATA_W-1:0] src_next;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DMA_IDLE;
      idx        <= '0;
      src        <= '0;
      latch      <= '0;
      dma_active <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      src        <= src_next;
      latch      <= latch_next;
      dma_active <= (state_next != DMA_IDLE);
    end
  end

  // Next state and bus request
  always_comb begin
    state_next = state;
    idx_next   = idx;
    src_next   = src;
    latch_next = latch;
    req        = '0;

    case (state)
      DMA_IDLE: begin
        state_next = DMA_IDLE;
      end
      DMA_READ: begin
        req.addr   = {src, idx};
        req.rd     = 1'b1;
        latch_next = bus_rdata;
        state_next = DMA_WRITE;
      end
      DMA_WRITE: begin
        req.addr  = OAM_BASE + {8'h00, idx};
        req.wdata = latch;
        // A restart in this cycle abandons the byte, so its write is dropped
        req.wr    = ~start;
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          state_next = DMA_IDLE;
        end else begin
          idx_next   = idx + IDX_W'(1);
          state_next = DMA_READ;
        end
      end
      default: begin
        state_next = DMA_IDLE;
      end
    endcase

    // Start or restart overrides whatever the current byte was doing
    if (start) begin
      src_next   = start_src;
      idx_next   = '0;
      state_next = DMA_READ;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares the downstream bus between the CPU and the
// OAM DMA engine, and holds the boot-ROM disable latch (0xFF50) and the
// DMA trigger register (0xFF46).
// Build option: define OAM_DMA_EN to include the DMA engine, the 0xFF46
// register and CPU blocking during DMA. Without it 0xFF46 is an ordinary
// bus address and dma_active is tied low.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   cpu_*            - CPU side; cpu_rdata is combinational
//   bus_*            - downstream memory/IO bus; bus_rdata valid by the
//                      edge ending a bus_rd cycle
//   bootrom_enabled  - registered boot ROM enable, cleared by 0xFF50 write
//   dma_active       - registered, high while DMA owns the bus
module mem_bus_arbiter
  import gb_mem_pkg::*;
#(
  parameter int unsigned       DMA_LEN  = DMA_LEN_DEFAULT,
  parameter logic [ADDR_W-1:0] OAM_BASE = OAM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bootrom_enabled,
  output logic              dma_active
);

  logic hit_boot;

  assign hit_boot = (cpu_addr == ADDR_BOOT_OFF);

  // Boot latch: one-way clear on a nonzero write, only reset re-arms it
  always_ff @(posedge clk) begin
    if (reset) begin
      bootrom_enabled <= 1'b1;
    end else if (cpu_wr && hit_boot && (cpu_wdata != '0)) begin
      bootrom_enabled <= 1'b0;
    end
  end

`ifdef OAM_DMA_EN

  logic              hit_dma;
  logic              dma_start;
  bus_req_t          dma_req;
  logic [DATA_W-1:0] dma_src;

  assign hit_dma   = (cpu_addr == ADDR_DMA);
  assign dma_start = cpu_wr & hit_dma;

  oam_dma_engine #(
    .DMA_LEN  (DMA_LEN),
    .OAM_BASE (OAM_BASE)
  ) u_dma (
    .clk        (clk),
    .reset      (reset),
    .start      (dma_start),
    .start_src  (cpu_wdata),
    .bus_rdata  (bus_rdata),
    .req        (dma_req),
    .dma_active (dma_active),
    .src        (dma_src)
  );

  // Bus mux: CPU passthrough unless DMA owns the bus; system registers
  // are absorbed here and never reach the bus
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_rd    = cpu_rd & ~hit_boot & ~hit_dma;
    bus_wr    = cpu_wr & ~hit_boot & ~hit_dma;
    cpu_rdata = bus_rdata;

    if (dma_active) begin
      bus_addr  = dma_req.addr;
      bus_wdata = dma_req.wdata;
      bus_rd    = dma_req.rd;
      bus_wr    = dma_req.wr;
      cpu_rdata = 8'hFF;
    end

    if (hit_dma) begin
      cpu_rdata = dma_src;
    end else if (hit_boot) begin
      cpu_rdata = 8'hFF;
    end
  end

`else

  assign dma_active = 1'b0;

  // Plain passthrough; only the boot latch is absorbed
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_rd    = cpu_rd & ~hit_boot;
    bus_wr    = cpu_wr & ~hit_boot;
    cpu_rdata = hit_boot ? 8'hFF : bus_rdata;
  end

`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned LEN       = 160;
  localparam logic [15:0] OAM       = 16'hFE00;
  localparam logic [15:0] A_BOOT    = 16'hFF50;
  localparam logic [15:0] A_DMA     = 16'hFF46;
`ifdef OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        bootrom_enabled;
  logic        dma_active;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rd          (cpu_rd),
    .cpu_wr          (cpu_wr),
    .cpu_rdata       (cpu_rdata),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rd          (bus_rd),
    .bus_wr          (bus_wr),
    .bus_rdata       (bus_rdata),
    .bootrom_enabled (bootrom_enabled),
    .dma_active      (dma_active)
  );

  // Downstream memory: combinational read, write on falling edge
  logic [7:0] mem      [65536];
  logic [7:0] ref_mem  [65536];
  logic [7:0] init_mem [65536];
  bit         mem_ready = 1'b0;
  bit         ref_ready = 1'b0;

  assign bus_rdata = mem[bus_addr];

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_mem[a];
      mem_ready <= 1'b1;
    end else if (bus_wr) begin
      mem[bus_addr] <= bus_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: boot flag, DMA on/off, source page, cycle count
  // within the transfer (byte = cnt/2, even = read, odd = write)
  bit         chk_en = 1'b0;
  bit         m_boot;
  bit         m_dma;
  logic [7:0] m_src;
  int         m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_boot <= 1'b1;
      m_dma  <= 1'b0;
      m_src  <= 8'h00;
      m_cnt  <= 0;
      chk_en <= 1'b1;
    end else begin
      if (cpu_wr && cpu_addr == A_BOOT && cpu_wdata != 8'h00) m_boot <= 1'b0;
      if (DMA_EN && cpu_wr && cpu_addr == A_DMA) begin
        m_src <= cpu_wdata;
        m_dma <= 1'b1;
        m_cnt <= 0;
      end else if (m_dma) begin
        if (m_cnt == 2 * LEN - 1) begin
          m_dma <= 1'b0;
          m_cnt <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [7:0]  e_rdata;
    logic        e_rd;
    logic        e_wr;
    logic        special;
    int          k;
    if (!ref_ready) begin
      for (int a = 0; a < 65536; a++) ref_mem[a] = init_mem[a];
      ref_ready = 1'b1;
    end
    if (chk_en) begin
      if (m_dma) begin
        k = m_cnt / 2;
        if (m_cnt % 2 == 0) begin
          e_addr  = {m_src, 8'(k)};
          e_rd    = 1'b1;
          e_wr    = 1'b0;
          e_wdata = 8'h00;
        end else begin
          e_addr  = OAM + 16'(k);
          e_rd    = 1'b0;
          e_wr    = !(cpu_wr && cpu_addr == A_DMA);
          e_wdata = ref_mem[{m_src, 8'(k)}];
        end
        e_rdata = 8'hFF;
      end else begin
        special = (cpu_addr == A_BOOT) || (DMA_EN && cpu_addr == A_DMA);
        e_addr  = cpu_addr;
        e_rd    = cpu_rd && !special;
        e_wr    = cpu_wr && !special;
        e_wdata = cpu_wdata;
        e_rdata = ref_mem[cpu_addr];
      end
      if (cpu_addr == A_BOOT) e_rdata = 8'hFF;
      else if (DMA_EN && cpu_addr == A_DMA) e_rdata = m_src;

      check("dma_active", 32'(dma_active), 32'(m_dma));
      check("bootrom_enabled", 32'(bootrom_enabled), 32'(m_boot));
      check("bus_rd", 32'(bus_rd), 32'(e_rd));
      check("bus_wr", 32'(bus_wr), 32'(e_wr));
      if (e_rd || e_wr || !m_dma) check("bus_addr", 32'(bus_addr), 32'(e_addr));
      if (e_wr) begin
        check("bus_wdata", 32'(bus_wdata), 32'(e_wdata));
        ref_mem[e_addr] = e_wdata;
      end
      if (cpu_rd) check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  int act_cnt;
  int errs;
  int op;

  initial begin
    for (int a = 0; a < 65536; a++) init_mem[a] = 8'($urandom);
    reset = 1'b1;
    idle();

    // Reset
    repeat (2) cyc();
    @(negedge clk);
    check("rst_bootrom_enabled", 32'(bootrom_enabled), 32'd1);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_strobes", {30'd0, bus_rd, bus_wr}, 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    cyc();
    reset = 1'b0;
    set_cpu(1'b1, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    check("read_0000", 32'(cpu_rdata), 32'(init_mem[0]));
    cyc();
`ifdef OAM_DMA_EN
    set_cpu(1'b1, 1'b0, A_DMA, 8'h00);
    @(negedge clk);
    check("rst_dma_src", 32'(cpu_rdata), 32'h00);
    cyc();
`endif

    // Boot latch
    set_cpu(1'b0, 1'b1, A_BOOT, 8'h00);
    cyc();
    idle();
    @(negedge clk);
    check("boot_wr0_keeps", 32'(bootrom_enabled), 32'd1);
    cyc();
    set_cpu(1'b0, 1'b1, A_BOOT, 8'h01);
    @(negedge clk);
    check("boot_wr_no_strobe", 32'(bus_wr), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("boot_cleared", 32'(bootrom_enabled), 32'd0);
    cyc();
    set_cpu(1'b0, 1'b1, A_BOOT, 8'h00);
    cyc();
    idle();
    @(negedge clk);
    check("boot_stays_cleared", 32'(bootrom_enabled), 32'd0);
    set_cpu(1'b1, 1'b0, A_BOOT, 8'h00);
    @(negedge clk);
    check("boot_read_ff", 32'(cpu_rdata), 32'hFF);
    cyc();

`ifdef OAM_DMA_EN
    // Full DMA with blocking checks
    set_cpu(1'b0, 1'b1, A_DMA, 8'hC1);
    cyc();
    act_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      idle();
      if (c == 20) set_cpu(1'b1, 1'b0, 16'hC000, 8'h00);
      if (c == 21) set_cpu(1'b0, 1'b1, 16'hC000, 8'h55);
      if (c == 22) set_cpu(1'b1, 1'b0, A_DMA, 8'h00);
      @(negedge clk);
      if (c == 0) check("first_read_addr", 32'(bus_addr), 32'hC100);
      if (dma_active) act_cnt++;
      if (c == 20) check("blk_read_ff", 32'(cpu_rdata), 32'hFF);
      if (c == 21) check("blk_wr_c000", 32'(bus_wr && bus_addr == 16'hC000), 32'd0);
      if (c == 22) check("blk_read_ff46", 32'(cpu_rdata), 32'hC1);
      cyc();
    end
    check("dma_active_cycles", 32'(act_cnt), 32'd320);
    errs = 0;
    for (int k = 0; k < LEN; k++) if (mem[OAM + 16'(k)] !== init_mem[16'hC100 + 16'(k)]) errs++;
    check("oam_copy_c1", 32'(errs), 32'd0);
    check("c000_unchanged", 32'(mem[16'hC000]), 32'(init_mem[16'hC000]));

    // Restart at byte 50
    set_cpu(1'b0, 1'b1, 16'hFE32, 8'h00);
    cyc();
    set_cpu(1'b0, 1'b1, A_DMA, 8'hC1);
    cyc();
    idle();
    repeat (100) cyc();
    set_cpu(1'b0, 1'b1, A_DMA, 8'hC2);
    @(negedge clk);
    check("restart_cycle_no_wr", 32'(bus_wr), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    check("restart_read_addr", 32'(bus_addr), 32'hC200);
    check("restart_read_strobe", 32'(bus_rd), 32'd1);
    check("fe32_not_from_c1", 32'(mem[16'hFE32]), 32'h00);
    repeat (330) cyc();
    @(negedge clk);
    check("restart_done", 32'(dma_active), 32'd0);
    errs = 0;
    for (int k = 0; k < LEN; k++) if (mem[OAM + 16'(k)] !== init_mem[16'hC200 + 16'(k)]) errs++;
    check("oam_copy_c2", 32'(errs), 32'd0);

    // Reset mid-transfer at byte 10
    set_cpu(1'b0, 1'b1, A_DMA, 8'hC1);
    cyc();
    idle();
    repeat (20) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {30'd0, bus_rd, bus_wr}, 32'd0);
    check("midrst_dma_active", 32'(dma_active), 32'd0);
    check("midrst_bootrom", 32'(bootrom_enabled), 32'd1);
    repeat (3) cyc();
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      op = int'($urandom_range(0, 9));
      idle();
      case (op)
        4: set_cpu(1'b1, 1'b0, {8'hD0, 8'($urandom)}, 8'h00);
        5: begin
          case ($urandom_range(0, 3))
            0: set_cpu(1'b1, 1'b0, A_BOOT, 8'h00);
            1: set_cpu(1'b1, 1'b0, A_DMA, 8'h00);
            2: set_cpu(1'b1, 1'b0, {8'hFE, 8'($urandom)}, 8'h00);
            default: set_cpu(1'b1, 1'b0, {8'h00, 8'($urandom)}, 8'h00);
          endcase
        end
        6, 7: set_cpu(1'b0, 1'b1, {8'hD0, 8'($urandom)}, 8'($urandom));
        8: set_cpu(1'b0, 1'b1, A_BOOT, 8'($urandom_range(0, 1)));
        9: if ($urandom_range(0, 29) == 0) set_cpu(1'b0, 1'b1, A_DMA, 8'hD0);
        default: idle();
      endcase
      cyc();
    end
    idle();
    repeat (340) cyc();
    @(negedge clk);
    check("final_idle", 32'(dma_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
